// File: rtl/txword_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : txword_arbiter_if
//  Description : Requester / transmitter bundle for txword_arbiter.
//                slave = arbiter view, master = environment view.
//  Revision    : 1.0  initial release
// ============================================================================
interface txword_arbiter_if #(
   parameter int NREQ = 2,
   parameter int DW   = 32,
   parameter int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
   logic [NREQ-1:0]    i_req;
   logic [NREQ*DW-1:0] i_data;
   logic [NREQ-1:0]    o_ack;
   logic               o_stb;
   logic [DW-1:0]      o_data;
   logic               i_busy;
   logic [GW-1:0]      o_grant;
   logic               o_active;

   modport slave (
      input  i_req, i_data, i_busy,
      output o_ack, o_stb, o_data, o_grant, o_active
   );

   modport master (
      output i_req, i_data, i_busy,
      input  o_ack, o_stb, o_data, o_grant, o_active
   );
endinterface
`default_nettype wire

// File: rtl/txword_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : txword_arbiter
//  Description : Round-robin arbiter sharing one serial word transmitter
//                between NREQ requesters, with optional inter-word gap.
//  Revision    : 1.0  initial release
// ============================================================================
module txword_arbiter #(
   parameter int NREQ       = 2,
   parameter int DW         = 32,
   parameter int GAP_CYCLES = 0
) (
   input  wire logic         i_clk,
   input  wire logic         i_reset,
   txword_arbiter_if.slave   bus
);
   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SEND  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;

   logic [1:0]      state_q,       state_d;
   logic [GW-1:0]   ptr_q,         ptr_d;
   logic [GW-1:0]   grant_q,       grant_d;
   logic [DW-1:0]   data_q,        data_d;
   logic            stb_q,         stb_d;
   logic [NREQ-1:0] ack_q,         ack_d;
   logic [CW-1:0]   gap_cnt_q,     gap_cnt_d;
   logic            drain_first_q, drain_first_d;

   logic            w_pick_valid;
   logic [GW-1:0]   w_pick_idx;
   logic [DW-1:0]   w_pick_data;
   int              w_idx;

   // Round-robin pick: first requester at or after ptr, wrapping at NREQ.
   always_comb begin
      w_pick_valid = 1'b0;
      w_pick_idx   = '0;
      w_pick_data  = '0;
      w_idx        = 0;
      for (int i = 0; i < NREQ; i++) begin
         w_idx = int'(ptr_q) + i;
         if (w_idx >= NREQ) w_idx = w_idx - NREQ;
         if (!w_pick_valid && bus.i_req[w_idx]) begin
            w_pick_valid = 1'b1;
            w_pick_idx   = GW'(w_idx);
            w_pick_data  = bus.i_data[w_idx*DW +: DW];
         end
      end
   end

   // State register; reset overrides everything, including a pending ack.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q       <= S_IDLE;
         ptr_q         <= '0;
         grant_q       <= '0;
         data_q        <= '0;
         stb_q         <= 1'b0;
         ack_q         <= '0;
         gap_cnt_q     <= '0;
         drain_first_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         grant_q       <= grant_d;
         data_q        <= data_d;
         stb_q         <= stb_d;
         ack_q         <= ack_d;
         gap_cnt_q     <= gap_cnt_d;
         drain_first_q <= drain_first_d;
      end
   end

   // Next-state logic: latch word in IDLE, hold in SEND until accepted,
   // wait out transmitter busy in DRAIN, then optional idle gap.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      grant_d       = grant_q;
      data_d        = data_q;
      stb_d         = stb_q;
      ack_d         = '0;
      gap_cnt_d     = gap_cnt_q;
      drain_first_d = drain_first_q;
      case (state_q)
         S_IDLE: begin
            if (w_pick_valid) begin
               state_d = S_SEND;
               stb_d   = 1'b1;
               grant_d = w_pick_idx;
               data_d  = w_pick_data;
            end
         end
         S_SEND: begin
            if (!bus.i_busy) begin
               state_d       = S_DRAIN;
               stb_d         = 1'b0;
               ack_d         = NREQ'(1) << grant_q;
               drain_first_d = 1'b1;
               if (int'(grant_q) == NREQ - 1) ptr_d = '0;
               else                           ptr_d = grant_q + 1'b1;
            end
         end
         S_DRAIN: begin
            // First DRAIN cycle ignores busy: the transmitter only raises
            // it the cycle after the accept.
            drain_first_d = 1'b0;
            if (!drain_first_q && !bus.i_busy) begin
               if (GAP_CYCLES > 0) begin
                  state_d   = S_GAP;
                  gap_cnt_d = CW'(GAP_CYCLES);
               end else begin
                  state_d   = S_IDLE;
               end
            end
         end
         S_GAP: begin
            gap_cnt_d = gap_cnt_q - 1'b1;
            if (gap_cnt_q <= CW'(1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs come straight from registers, so there are no glitches.
   always_comb begin
      bus.o_stb    = stb_q;
      bus.o_data   = data_q;
      bus.o_grant  = grant_q;
      bus.o_ack    = ack_q;
      bus.o_active = (state_q != S_IDLE);
   end
endmodule
`default_nettype wire
